plru_state_array: RTL and testbench
===================================

Name: plru_state_array

Overview:
- Per-set tree pseudo-LRU state store for N-way set-associative caches. It generalises the 4-way LRU state array to any power-of-two associativity.
- Owns the PLRU update and victim-selection logic, so cache controllers issue "touch way" and "query victim" operations instead of raw bit writes.
- Adds a runtime flush sweep that clears all sets without a reset.
- Sits beside the tag/data arrays in the cache datapath.

Parameters:
- S_INDEX, 4, set-index width; NUM_SETS = 2**S_INDEX.
- WAYS, 4, associativity; power of two, at least 2. Each set holds WAYS-1 state bits; WAY_IDX = $clog2(WAYS) is derived.

Ports:
- clk0  in  1  clock.
- rst0  in  1  reset; asynchronous, active-high.
- flush_req  in  1  start a clear sweep of all sets.
- busy  out  1  sweep in progress.
- vic_req  in  1  victim query strobe.
- vic_set  in  S_INDEX  set to query.
- vic_valid  out  1  vic_way is valid this cycle.
- vic_way  out  WAY_IDX  selected victim way.
- touch_req  in  1  mark a way most-recently-used.
- touch_set  in  S_INDEX  set being touched.
- touch_way  in  WAY_IDX  way being touched.

Behaviour:
- State encoding: heap-ordered tree. Node 0 is the root; the children of node i are 2i+1 and 2i+2.
  - A node bit of 0 points the victim to the left (lower-numbered ways); 1 points right.
- Victim walk: start at the root and follow the node bits to a leaf. All-zero state gives way 0.
- Touch: every node on the path to touch_way is set to point away from touch_way. Nodes off the path are unchanged.
- Reset (rst0 high, asynchronous):
  - All state bits cleared.
  - Request registers cleared; touch and query pending flags are 0.
  - FSM goes to IDLE.
  - busy=0, vic_valid=0, vic_way=0.
  - This applies immediately, including in the middle of a sweep.
- Query timing (1-cycle latency, SRAM-like):
  - vic_req/vic_set are registered at edge E.
  - vic_valid=1 and vic_way are driven combinationally during the cycle after E.
  - vic_valid=0 in any cycle with no registered query.
  - vic_way is held at its last value when vic_valid=0.
- Touch timing:
  - touch_req/touch_set/touch_way are registered at edge E.
  - The updated bits are written to the array at edge E+1.
- Forwarding: if the registered query set equals the registered pending touch set, vic_way is computed from the post-touch bits. A touch and a query in the same cycle to the same set therefore return the post-touch victim.
- Back-to-back touches to the same set on consecutive cycles must compose correctly. The second touch updates from the forwarded post-first-touch bits, not the stale array value.
- FSM states IDLE and SWEEP:
  - IDLE -> SWEEP when flush_req=1 at an edge. The counter is loaded with 0.
  - In SWEEP, set[counter] is written to all-zero at each edge and the counter increments.
  - SWEEP -> IDLE at the edge that clears set NUM_SETS-1.
  - busy=1 for exactly NUM_SETS cycles, starting the cycle after acceptance.
- Flush priority:
  - A touch already registered before flush acceptance still commits at the acceptance edge.
  - A touch_req or vic_req presented in the acceptance cycle is dropped.
  - All requests presented while busy=1 are ignored: no state change, and vic_valid=0 in the following cycle.
  - flush_req while busy=1 is ignored; the sweep is not restarted.
- Counter width is S_INDEX. The sweep ends on the terminal compare, never on counter wrap.

Decomposition:
- plru_pkg holds:
  - function plru_victim(bits) returning a way index;
  - function plru_update(bits, way) returning next bits;
  - the FSM state enum (IDLE, SWEEP).
  - Functions are parameterised through WAYS via loops bounded by $clog2.
- One sub-module, plru_tree (combinational): takes state bits and a touch way, and produces next bits and the victim way. It is instantiated twice: once for the update path and once for the forwarded query path.
- The top level holds the state array, request registers, forwarding muxes and the sweep FSM/counter.

Test Plan:
1. Reset, then vic_req set 3 -> one cycle later vic_valid=1, vic_way=0. In the cycle after that, vic_valid=0.
2. WAYS=4, set 5: touch way 0 -> query gives 2; then touch way 2 -> 1; then touch way 1 -> 3. Each query is issued two or more cycles after its touch.
3. Forwarding: touch set 7 way 0 and vic_req set 7 in the same cycle -> vic_way=2. A query to set 6 in the same cycle -> 0.
4. Flush:
   - Touch sets 0, 9 and 15 (way 0 each), then pulse flush_req.
   - busy is high for exactly 16 cycles, and vic_req during busy gives vic_valid=0.
   - After busy falls, querying sets 0, 9 and 15 gives 0 for each.
5. Async reset mid-sweep: assert rst0 between edges at sweep count 8 -> busy=0 and vic_valid=0 immediately, without waiting for an edge. After release, any set query returns 0.
6. WAYS=8, set 1:
   - Touch way 7 -> query gives 0.
   - Touch ways 0..7 in order -> 0.
   - Touch way 0 -> 4.
   - Touch ways 0 and 4 on back-to-back cycles -> 2, which checks touch-touch forwarding.

Source files
------------

// File: rtl/plru_pkg.sv
// Shared types and tree pseudo-LRU helpers for the per-set PLRU state store.
// Functions work on a maximum-width tree; callers pass the real way-index width.
package plru_pkg;

  localparam int unsigned MAX_WAYS = 64;
  localparam int unsigned MAX_IDX  = 6;

  typedef logic [MAX_WAYS-2:0] plru_bits_t;
  typedef logic [MAX_IDX-1:0]  plru_way_t;

  typedef enum logic {IDLE, SWEEP} plru_state_e;

  // Walk from the root following node bits (0 = left, 1 = right) to a leaf.
  function automatic plru_way_t plru_victim(input plru_bits_t bits, input int unsigned idx_w);
    plru_way_t way;
    plru_way_t node;
    logic      dir;
    way  = '0;
    node = '0;
    for (int unsigned lvl = 0; lvl < MAX_IDX; lvl++) begin
      if (lvl < idx_w) begin
        dir  = bits[node];
        way  = {way[MAX_IDX-2:0], dir};
        node = {node[MAX_IDX-2:0], 1'b0} + MAX_IDX'(1) + MAX_IDX'(dir);
      end
    end
    return way;
  endfunction

  // Point every node on the path to 'way' away from it; other nodes keep their value.
  function automatic plru_bits_t plru_update(input plru_bits_t bits, input plru_way_t way,
                                             input int unsigned idx_w);
    plru_bits_t nb;
    plru_way_t  ws;
    plru_way_t  node;
    logic       dir;
    nb   = bits;
    ws   = way << (MAX_IDX - idx_w);
    node = '0;
    for (int unsigned lvl = 0; lvl < MAX_IDX; lvl++) begin
      if (lvl < idx_w) begin
        dir      = ws[MAX_IDX-1];
        nb[node] = ~dir;
        node     = {node[MAX_IDX-2:0], 1'b0} + MAX_IDX'(1) + MAX_IDX'(dir);
        ws       = ws << 1;
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/plru_state_array_tree.sv
// Combinational PLRU tree: next state after touching a way, and the victim of the given state.
module plru_tree
  import plru_pkg::*;
#(
  parameter  int unsigned WAYS    = 4,
  localparam int unsigned WAY_IDX = $clog2(WAYS),
  localparam int unsigned NODES   = WAYS - 1
) (
  input  logic [NODES-1:0]   i_bits,
  input  logic [WAY_IDX-1:0] i_way,
  output logic [NODES-1:0]   o_next,
  output logic [WAY_IDX-1:0] o_victim
);

  assign o_next   = NODES'(plru_update(plru_bits_t'(i_bits), plru_way_t'(i_way), WAY_IDX));
  assign o_victim = WAY_IDX'(plru_victim(plru_bits_t'(i_bits), WAY_IDX));

endmodule

// File: rtl/plru_state_array.sv
// Per-set tree pseudo-LRU state store with touch/victim-query ports and a flush sweep.
// Query results appear combinationally one cycle after the request, forwarded past a pending touch.
module plru_state_array
  import plru_pkg::*;
#(
  parameter  int unsigned S_INDEX = 4,
  parameter  int unsigned WAYS    = 4,
  localparam int unsigned WAY_IDX = $clog2(WAYS)
) (
  input  logic               clk0,
  input  logic               rst0,
  input  logic               flush_req,
  output logic               busy,
  input  logic               vic_req,
  input  logic [S_INDEX-1:0] vic_set,
  output logic               vic_valid,
  output logic [WAY_IDX-1:0] vic_way,
  input  logic               touch_req,
  input  logic [S_INDEX-1:0] touch_set,
  input  logic [WAY_IDX-1:0] touch_way
);

  localparam int unsigned NUM_SETS = 2 ** S_INDEX;
  localparam int unsigned NODES    = WAYS - 1;

  logic [NODES-1:0]   r_bits [NUM_SETS];
  plru_state_e        r_state;
  logic [S_INDEX-1:0] r_cnt;
  logic               r_t_valid;
  logic [S_INDEX-1:0] r_t_set;
  logic [WAY_IDX-1:0] r_t_way;
  logic               r_q_valid;
  logic [S_INDEX-1:0] r_q_set;
  logic [WAY_IDX-1:0] r_last_way;

  logic               w_accept;
  logic [NODES-1:0]   w_t_next;
  logic [NODES-1:0]   w_q_bits;
  logic [WAY_IDX-1:0] w_q_victim;
  logic [WAY_IDX-1:0] w_unused_t_victim;
  logic [NODES-1:0]   w_unused_q_next;

  // New requests are only taken while idle and not in a flush-acceptance cycle.
  assign w_accept = (r_state == IDLE) && !flush_req;

  plru_tree #(.WAYS(WAYS)) u_touch_tree (
    .i_bits   (r_bits[r_t_set]),
    .i_way    (r_t_way),
    .o_next   (w_t_next),
    .o_victim (w_unused_t_victim)
  );

  // A query to the set with a pending touch sees the post-touch bits.
  assign w_q_bits = (r_t_valid && (r_t_set == r_q_set)) ? w_t_next : r_bits[r_q_set];

  plru_tree #(.WAYS(WAYS)) u_query_tree (
    .i_bits   (w_q_bits),
    .i_way    ('0),
    .o_next   (w_unused_q_next),
    .o_victim (w_q_victim)
  );

  assign busy      = (r_state == SWEEP);
  assign vic_valid = r_q_valid;
  assign vic_way   = r_q_valid ? w_q_victim : r_last_way;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      for (int i = 0; i < int'(NUM_SETS); i++) r_bits[i] <= '0;
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_t_valid  <= 1'b0;
      r_t_set    <= '0;
      r_t_way    <= '0;
      r_q_valid  <= 1'b0;
      r_q_set    <= '0;
      r_last_way <= '0;
    end else begin
      if (r_q_valid) r_last_way <= w_q_victim;

      if (r_state == SWEEP) r_bits[r_cnt] <= '0;
      else if (r_t_valid) r_bits[r_t_set] <= w_t_next;

      case (r_state)
        IDLE: begin
          if (flush_req) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
          end
        end
        SWEEP: begin
          r_cnt <= r_cnt + S_INDEX'(1);
          if (r_cnt == S_INDEX'(NUM_SETS - 1)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      r_t_valid <= w_accept && touch_req;
      r_q_valid <= w_accept && vic_req;
      if (w_accept) begin
        r_t_set <= touch_set;
        r_t_way <= touch_way;
        r_q_set <= vic_set;
      end
    end
  end

endmodule

// File: tb/tb_plru_state_array.sv
// Directed bench for plru_state_array: a 4-way and an 8-way instance share clock and reset.
module tb_plru_state_array;

  logic       clk = 1'b0;
  logic       rst0;

  logic       flush4, busy4, vreq4, vvalid4, treq4;
  logic [3:0] vset4, tset4;
  logic [1:0] vway4, tway4;

  logic       flush8, busy8, vreq8, vvalid8, treq8;
  logic [3:0] vset8, tset8;
  logic [2:0] vway8, tway8;

  int n_asserts = 0;
  int n_fail    = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  plru_state_array #(.S_INDEX(4), .WAYS(4)) dut4 (
    .clk0(clk), .rst0(rst0), .flush_req(flush4), .busy(busy4),
    .vic_req(vreq4), .vic_set(vset4), .vic_valid(vvalid4), .vic_way(vway4),
    .touch_req(treq4), .touch_set(tset4), .touch_way(tway4)
  );

  plru_state_array #(.S_INDEX(4), .WAYS(8)) dut8 (
    .clk0(clk), .rst0(rst0), .flush_req(flush8), .busy(busy8),
    .vic_req(vreq8), .vic_set(vset8), .vic_valid(vvalid8), .vic_way(vway8),
    .touch_req(treq8), .touch_set(tset8), .touch_way(tway8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic touch4(input logic [3:0] s, input logic [1:0] w);
    treq4 = 1'b1; tset4 = s; tway4 = w;
    tick();
    treq4 = 1'b0;
  endtask

  task automatic query4(input string tag, input logic [3:0] s, input logic [1:0] exp);
    vreq4 = 1'b1; vset4 = s;
    tick();
    vreq4 = 1'b0;
    chk({tag, "_valid"}, 32'(vvalid4), 32'd1);
    chk(tag, 32'(vway4), 32'(exp));
  endtask

  task automatic touch8(input logic [3:0] s, input logic [2:0] w);
    treq8 = 1'b1; tset8 = s; tway8 = w;
    tick();
    treq8 = 1'b0;
  endtask

  task automatic query8(input string tag, input logic [3:0] s, input logic [2:0] exp);
    vreq8 = 1'b1; vset8 = s;
    tick();
    vreq8 = 1'b0;
    chk({tag, "_valid"}, 32'(vvalid8), 32'd1);
    chk(tag, 32'(vway8), 32'(exp));
  endtask

  initial begin
    rst0 = 1'b1;
    flush4 = 1'b0; vreq4 = 1'b0; vset4 = '0; treq4 = 1'b0; tset4 = '0; tway4 = '0;
    flush8 = 1'b0; vreq8 = 1'b0; vset8 = '0; treq8 = 1'b0; tset8 = '0; tway8 = '0;
    #1;
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_valid4", 32'(vvalid4), 32'd0);
    chk("rst_way4", 32'(vway4), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_valid8", 32'(vvalid8), 32'd0);
    repeat (2) tick();
    rst0 = 1'b0;
    tick();

    // Single query after reset, then the valid strobe drops.
    query4("q_reset_set3", 4'd3, 2'd0);
    tick();
    chk("q_reset_valid_drop", 32'(vvalid4), 32'd0);

    // Touch sequence on set 5.
    touch4(4'd5, 2'd0); tick();
    query4("s5_after_w0", 4'd5, 2'd2);
    touch4(4'd5, 2'd2); tick();
    query4("s5_after_w2", 4'd5, 2'd1);
    touch4(4'd5, 2'd1); tick();
    query4("s5_after_w1", 4'd5, 2'd3);
    tick();
    chk("hold_valid", 32'(vvalid4), 32'd0);
    chk("hold_way", 32'(vway4), 32'd3);

    // Same-cycle touch and query forwarding.
    treq4 = 1'b1; tset4 = 4'd7; tway4 = 2'd0; vreq4 = 1'b1; vset4 = 4'd7;
    tick();
    treq4 = 1'b0; vreq4 = 1'b0;
    chk("fwd_s7_valid", 32'(vvalid4), 32'd1);
    chk("fwd_s7", 32'(vway4), 32'd2);
    treq4 = 1'b1; tset4 = 4'd7; tway4 = 2'd1; vreq4 = 1'b1; vset4 = 4'd6;
    tick();
    treq4 = 1'b0; vreq4 = 1'b0;
    chk("nofwd_s6", 32'(vway4), 32'd0);
    tick();
    query4("s7_after_w0_w1", 4'd7, 2'd2);

    // Flush sweep with requests presented while busy.
    touch4(4'd0, 2'd0);
    touch4(4'd9, 2'd0);
    touch4(4'd15, 2'd0);
    tick();
    query4("pre_flush_s9", 4'd9, 2'd2);
    flush4 = 1'b1;
    tick();
    flush4 = 1'b0;
    busy_cnt = 0;
    for (int g = 0; g < 40; g++) begin
      if (busy4) begin
        busy_cnt++;
        vreq4 = 1'b1; vset4 = 4'd9;
        treq4 = 1'b1; tset4 = 4'd0; tway4 = 2'd0;
        flush4 = (busy_cnt == 5);
        tick();
        vreq4 = 1'b0; treq4 = 1'b0; flush4 = 1'b0;
        chk("busy_vic_valid", 32'(vvalid4), 32'd0);
      end
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd16);
    query4("post_flush_s0", 4'd0, 2'd0);
    query4("post_flush_s9", 4'd9, 2'd0);
    query4("post_flush_s15", 4'd15, 2'd0);

    // Asynchronous reset in the middle of a sweep.
    touch4(4'd3, 2'd0); tick();
    query4("pre_rst_s3", 4'd3, 2'd2);
    flush4 = 1'b1;
    tick();
    flush4 = 1'b0;
    chk("sweep_started", 32'(busy4), 32'd1);
    repeat (8) tick();
    #2;
    rst0 = 1'b1;
    #1;
    chk("async_busy", 32'(busy4), 32'd0);
    chk("async_valid", 32'(vvalid4), 32'd0);
    chk("async_way", 32'(vway4), 32'd0);
    tick();
    rst0 = 1'b0;
    tick();
    query4("after_rst_s3", 4'd3, 2'd0);
    query4("after_rst_s12", 4'd12, 2'd0);

    // 8-way tree on set 1.
    touch8(4'd1, 3'd7); tick();
    query8("w8_after_7", 4'd1, 3'd0);
    for (int w = 0; w < 8; w++) touch8(4'd1, 3'(w));
    tick();
    query8("w8_after_0to7", 4'd1, 3'd0);
    touch8(4'd1, 3'd0); tick();
    query8("w8_after_0", 4'd1, 3'd4);
    touch8(4'd1, 3'd0);
    touch8(4'd1, 3'd4);
    tick();
    query8("w8_b2b_0_4", 4'd1, 3'd2);
    touch8(4'd1, 3'd0);
    treq8 = 1'b1; tset8 = 4'd1; tway8 = 3'd4; vreq8 = 1'b1; vset8 = 4'd1;
    tick();
    treq8 = 1'b0; vreq8 = 1'b0;
    chk("w8_b2b_fwd", 32'(vway8), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
